// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port arbiter for the data-memory port with locked bursts.
//           Define DMEM_ARB_RR_EN for round-robin tie-breaking in ARB.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 64,
  parameter int MASK_WID = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic                p0_lock,
  input  logic [ADDR_WID-1:0] p0_addr,
  input  logic                p0_wr_en,
  input  logic [DATA_WID-1:0] p0_wdata,
  input  logic [MASK_WID-1:0] p0_wmask,
  output logic                p0_gnt,
  output logic                p0_rvalid,
  output logic [DATA_WID-1:0] p0_rdata,
  input  logic                p1_req,
  input  logic                p1_lock,
  input  logic [ADDR_WID-1:0] p1_addr,
  input  logic                p1_wr_en,
  input  logic [DATA_WID-1:0] p1_wdata,
  input  logic [MASK_WID-1:0] p1_wmask,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic [DATA_WID-1:0] p1_rdata,
  output logic [ADDR_WID-1:0] mem_addr,
  output logic                mem_wr_en,
  output logic [DATA_WID-1:0] mem_wdata,
  output logic [MASK_WID-1:0] mem_wmask,
  input  logic [DATA_WID-1:0] mem_rdata
);

  localparam int                   c_CNT_WID    = $clog2(MAX_LOCK + 1);
  localparam logic [c_CNT_WID-1:0] c_MAX_CNT    = c_CNT_WID'(MAX_LOCK);
  localparam logic [ADDR_WID-1:0]  c_ALIGN_MASK = ~ADDR_WID'(7);

  // REL0/REL1 behave as ARB but force the named port to win once.
  typedef enum logic [2:0] {
    ST_ARB   = 3'd0,
    ST_LOCK0 = 3'd1,
    ST_LOCK1 = 3'd2,
    ST_REL0  = 3'd3,
    ST_REL1  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [c_CNT_WID-1:0]   lock_cnt_q;
  logic                   rd_pend_q;
  logic                   rd_tag_q;

  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_any;
  logic                   w_wr;
  logic                   w_lock;
  logic                   w_other_req;
  logic                   w_owned;
  logic                   w_tie_p1;
  logic [c_CNT_WID-1:0]   w_cnt_base;
  logic [c_CNT_WID-1:0]   w_cnt_inc;
  logic [ADDR_WID-1:0]    w_addr;

`ifdef DMEM_ARB_RR_EN
  logic                   last_p1_q;
  assign w_tie_p1 = ~last_p1_q;
`else
  assign w_tie_p1 = 1'b0;
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (state_q)
      ST_LOCK0: w_gnt0 = p0_req;
      ST_LOCK1: w_gnt1 = p1_req;
      ST_REL0: begin
        w_gnt0 = p0_req;
        w_gnt1 = p1_req & ~p0_req;
      end
      ST_REL1: begin
        w_gnt1 = p1_req;
        w_gnt0 = p0_req & ~p1_req;
      end
      default: begin
        w_gnt1 = p1_req & (~p0_req | w_tie_p1);
        w_gnt0 = p0_req & ~w_gnt1;
      end
    endcase
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_any       = w_gnt0 | w_gnt1;
  assign w_wr        = w_gnt1 ? p1_wr_en : p0_wr_en;
  assign w_lock      = w_gnt1 ? p1_lock  : p0_lock;
  assign w_other_req = w_gnt1 ? p0_req   : p1_req;
  assign w_owned     = (state_q == ST_LOCK0) || (state_q == ST_LOCK1);
  assign w_cnt_base  = w_owned ? lock_cnt_q : '0;
  assign w_cnt_inc   = (w_cnt_base >= c_MAX_CNT) ? c_MAX_CNT : w_cnt_base + 1'b1;

  assign w_addr    = w_gnt1 ? p1_addr : (w_gnt0 ? p0_addr : '0);
  assign mem_addr  = w_addr & c_ALIGN_MASK;
  assign mem_wr_en = w_any & w_wr;
  assign mem_wdata = w_gnt1 ? p1_wdata : (w_gnt0 ? p0_wdata : '0);
  assign mem_wmask = w_gnt1 ? p1_wmask : (w_gnt0 ? p0_wmask : '0);

  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;
  assign p0_rvalid = rd_pend_q & ~rd_tag_q & ~rst;
  assign p1_rvalid = rd_pend_q &  rd_tag_q & ~rst;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_p1_q  <= 1'b1;
`endif
    end else begin
      rd_pend_q <= w_any & ~w_wr;
      rd_tag_q  <= w_gnt1;
      if (w_any) begin
        if (w_lock) begin
          // Owner hit the lock budget with the other port waiting: hand over once.
          if ((w_cnt_inc >= c_MAX_CNT) && w_other_req) begin
            state_q    <= w_gnt1 ? ST_REL0 : ST_REL1;
            lock_cnt_q <= '0;
          end else begin
            state_q    <= w_gnt1 ? ST_LOCK1 : ST_LOCK0;
            lock_cnt_q <= w_cnt_inc;
          end
        end else begin
          state_q    <= ST_ARB;
          lock_cnt_q <= '0;
        end
      end else if (!w_owned) begin
        state_q <= ST_ARB;
      end
`ifdef DMEM_ARB_RR_EN
      if (w_any && !w_owned) begin
        last_p1_q <= w_gnt1;
      end
`endif
    end
  end

endmodule
`default_nettype wire
